// File: rtl/grid_frame_buffer_if.sv
// Bus between the VGA controller / game logic (master) and the grid frame buffer (slave).
// Carries the cell query path plus the back-buffer write, clear and commit controls.
interface grid_frame_buffer_if #(
  parameter int GRID_W = 10
);
  logic [7:0]        x_coord;
  logic [7:0]        y_coord;
  logic              coord_value;
  logic              draw_finish;
  logic              wr_en;
  logic [4:0]        wr_row;
  logic [GRID_W-1:0] wr_data;
  logic              clear_req;
  logic              commit;
  logic              wr_ready;
  logic              swap_pending;
  logic              frame_sel;

  modport master (
    output x_coord, y_coord, draw_finish, wr_en, wr_row, wr_data, clear_req, commit,
    input  coord_value, wr_ready, swap_pending, frame_sel
  );

  modport slave (
    input  x_coord, y_coord, draw_finish, wr_en, wr_row, wr_data, clear_req, commit,
    output coord_value, wr_ready, swap_pending, frame_sel
  );
endinterface

// File: rtl/grid_frame_buffer.sv
// Double-buffered Tetris well: game logic fills the back buffer, VGA scan reads the front.
// Define GRID_BORDER_EN to make out-of-range queries draw the right wall and the floor.
module grid_frame_buffer #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 20
) (
  input logic               vga_clk,
  input logic               reset,
  grid_frame_buffer_if.slave bus
);

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [7:0] GRID_W8  = 8'(GRID_W);
  localparam logic [7:0] GRID_H8  = 8'(GRID_H);
  localparam logic [4:0] GRID_H5  = 5'(GRID_H);
  localparam logic [4:0] LAST_ROW = 5'(GRID_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COPY
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        rowCnt_q, rowCnt_d;
  logic              swapPending_q, swapPending_d;
  logic              frameSel_q, frameSel_d;
  logic              coordValue_q, coordValue_d;
  logic              doWrite, doClear, doCopy;
  logic              borderBit;

  // mem_q[frameSel_q] is the displayed frame; the other entry is the back buffer
  logic [GRID_W-1:0] mem_q [2][GRID_H];

  assign bus.coord_value  = coordValue_q;
  assign bus.wr_ready     = (state_q == IDLE);
  assign bus.swap_pending = swapPending_q;
  assign bus.frame_sel    = frameSel_q;

`ifdef GRID_BORDER_EN
  assign borderBit = (bus.x_coord == GRID_W8) ||
                     ((bus.y_coord == GRID_H8) && (bus.x_coord <= GRID_W8));
`else
  assign borderBit = 1'b0;
`endif

  always_comb begin
    coordValue_d = borderBit;
    if ((bus.x_coord < GRID_W8) && (bus.y_coord < GRID_H8)) begin
      coordValue_d = mem_q[frameSel_q][bus.y_coord[YW-1:0]][bus.x_coord[XW-1:0]];
    end
  end

  always_comb begin
    state_d       = state_q;
    rowCnt_d      = rowCnt_q;
    swapPending_d = swapPending_q;
    frameSel_d    = frameSel_q;
    doWrite       = 1'b0;
    doClear       = 1'b0;
    doCopy        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d  = CLEAR;
          rowCnt_d = '0;
        end else begin
          doWrite = bus.wr_en && (bus.wr_row < GRID_H5);
          // A same-cycle write lands in the old back buffer, which is about to become the front
          if (bus.draw_finish && (swapPending_q || bus.commit)) begin
            frameSel_d    = ~frameSel_q;
            swapPending_d = 1'b0;
            state_d       = COPY;
            rowCnt_d      = '0;
          end else if (bus.commit) begin
            swapPending_d = 1'b1;
          end
        end
      end
      CLEAR, COPY: begin
        doClear = (state_q == CLEAR);
        doCopy  = (state_q == COPY);
        if (rowCnt_q == LAST_ROW) begin
          state_d  = IDLE;
          rowCnt_d = '0;
        end else begin
          rowCnt_d = rowCnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rowCnt_q      <= '0;
      swapPending_q <= 1'b0;
      frameSel_q    <= 1'b0;
      coordValue_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < GRID_H; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else begin
      state_q       <= state_d;
      rowCnt_q      <= rowCnt_d;
      swapPending_q <= swapPending_d;
      frameSel_q    <= frameSel_d;
      coordValue_q  <= coordValue_d;
      if (doWrite) begin
        mem_q[~frameSel_q][bus.wr_row[YW-1:0]] <= bus.wr_data;
      end
      if (doClear) begin
        mem_q[~frameSel_q][rowCnt_q[YW-1:0]] <= '0;
      end
      // In COPY frameSel_q already points at the new front, so this refreshes the back from it
      if (doCopy) begin
        mem_q[~frameSel_q][rowCnt_q[YW-1:0]] <= mem_q[frameSel_q][rowCnt_q[YW-1:0]];
      end
    end
  end

endmodule
